register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 76 +++++++
 tb/tb_register_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// 32-entry flop-based register file: two combinational read ports with write bypass,
// one write port, and a hardwired-zero register.
module register_bank #(
   parameter int WIDTH    = 32,
   parameter int ZERO_REG = 31
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   RegWrite,
   input  logic [4:0]             WriteRegister,
   input  logic [WIDTH-1:0]       WriteData,
   input  logic [4:0]             ReadRegister1,
   input  logic [4:0]             ReadRegister2,
   output logic [WIDTH-1:0]       ReadData1,
   output logic [WIDTH-1:0]       ReadData2,
   output logic [31:0][WIDTH-1:0] regs
);

   localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

   logic [31:0][WIDTH-1:0] mem;
   logic [31:0]            wr_en;
   logic                   bypass_ok;

   // One-hot write decode; the zero register never gets an enable.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latch is inferred.
      wr_en = '0;
      if (RegWrite) begin
         wr_en[WriteRegister] = 1'b1;
      end
      wr_en[ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: this bank is built from flops, so clearing it asynchronously is legal;
         // a RAM macro could not be cleared this way.
         mem <= '0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (wr_en[i]) begin
               // NOTE: state is updated with non-blocking assignments only.
               mem[i] <= WriteData;
            end
         end
      end
   end

   assign regs      = mem;
   assign bypass_ok = RegWrite && !reset && (WriteRegister != ZERO_IDX);

   // Read ports: zero register and reset win, then same-cycle bypass, then storage.
   always_comb begin
      ReadData1 = '0;
      if (!reset && ReadRegister1 != ZERO_IDX) begin
         if (bypass_ok && ReadRegister1 == WriteRegister) begin
            ReadData1 = WriteData;
         end else begin
            ReadData1 = mem[ReadRegister1];
         end
      end
   end

   always_comb begin
      ReadData2 = '0;
      if (!reset && ReadRegister2 != ZERO_IDX) begin
         if (bypass_ok && ReadRegister2 == WriteRegister) begin
            ReadData2 = WriteData;
         end else begin
            ReadData2 = mem[ReadRegister2];
         end
      end
   end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, write/read, hold,
// zero register, bypass, back-to-back writes, full sweep and mid-run reset.
module tb_register_bank;

   logic              clk;
   logic              reset;
   logic              RegWrite;
   logic [4:0]        WriteRegister;
   logic [31:0]       WriteData;
   logic [4:0]        ReadRegister1;
   logic [4:0]        ReadRegister2;
   logic [31:0]       ReadData1;
   logic [31:0]       ReadData2;
   logic [31:0][31:0] regs;

   int checks   = 0;
   int failures = 0;

   register_bank #(.WIDTH(32), .ZERO_REG(31)) dut (
      .clk           (clk),
      .reset         (reset),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .regs          (regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one write on the next rising edge, then return just after it.
   task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = addr;
      WriteData     = data;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_reset;
      reset         = 1'b1;
      RegWrite      = 1'b1;
      WriteRegister = 5'd5;
      WriteData     = 32'h0000_0055;
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd5;
      @(posedge clk);
      #1;
      checks++;
      if (regs !== '0) begin
         failures++;
         $display("FAIL reset_regs: got %h want all zero", regs);
      end
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         failures++;
         $display("FAIL reset_bypass_off: rd1=%h rd2=%h want 0", ReadData1, ReadData2);
      end
      @(negedge clk);
      reset    = 1'b0;
      RegWrite = 1'b0;
   endtask

   task automatic test_write_read;
      do_write(5'd3, 32'h0000_00A5);
      ReadRegister1 = 5'd3;
      #1;
      checks++;
      if (ReadData1 !== 32'h0000_00A5) begin
         failures++;
         $display("FAIL write_read_rd1: got %h want 000000a5", ReadData1);
      end
      checks++;
      if (regs[3] !== 32'h0000_00A5) begin
         failures++;
         $display("FAIL write_read_regs3: got %h want 000000a5", regs[3]);
      end
   endtask

   task automatic test_hold;
      @(negedge clk);
      RegWrite      = 1'b0;
      WriteRegister = 5'd4;
      WriteData     = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (regs[4] !== 32'h0) begin
         failures++;
         $display("FAIL hold_regs4: got %h want 00000000", regs[4]);
      end
      checks++;
      if (regs[3] !== 32'h0000_00A5) begin
         failures++;
         $display("FAIL hold_regs3: got %h want 000000a5", regs[3]);
      end
   endtask

   task automatic test_zero_reg;
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd31;
      WriteData     = 32'h1234_5678;
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd31;
      #1;
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         failures++;
         $display("FAIL zero_no_bypass: rd1=%h rd2=%h want 0", ReadData1, ReadData2);
      end
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      checks++;
      if (regs[31] !== 32'h0) begin
         failures++;
         $display("FAIL zero_regs31: got %h want 00000000", regs[31]);
      end
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         failures++;
         $display("FAIL zero_read: rd1=%h rd2=%h want 0", ReadData1, ReadData2);
      end
   endtask

   task automatic test_bypass;
      do_write(5'd7, 32'h0000_0011);
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd7;
      WriteData     = 32'hDEAD_BEEF;
      ReadRegister1 = 5'd7;
      ReadRegister2 = 5'd7;
      #1;
      checks++;
      if (ReadData1 !== 32'hDEAD_BEEF || ReadData2 !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL bypass_both: rd1=%h rd2=%h want deadbeef", ReadData1, ReadData2);
      end
      checks++;
      if (regs[7] !== 32'h0000_0011) begin
         failures++;
         $display("FAIL bypass_regs_old: got %h want 00000011", regs[7]);
      end
      // Only port 1 matches the write address here.
      ReadRegister2 = 5'd3;
      #1;
      checks++;
      if (ReadData1 !== 32'hDEAD_BEEF || ReadData2 !== 32'h0000_00A5) begin
         failures++;
         $display("FAIL bypass_indep: rd1=%h rd2=%h want deadbeef/000000a5", ReadData1, ReadData2);
      end
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      checks++;
      if (regs[7] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL bypass_regs_new: got %h want deadbeef", regs[7]);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd9;
      WriteData     = 32'h0000_0001;
      @(posedge clk);
      #1;
      checks++;
      if (regs[9] !== 32'h0000_0001) begin
         failures++;
         $display("FAIL b2b_first: got %h want 00000001", regs[9]);
      end
      WriteData = 32'h0000_0002;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      checks++;
      if (regs[9] !== 32'h0000_0002) begin
         failures++;
         $display("FAIL b2b_last: got %h want 00000002", regs[9]);
      end
   endtask

   task automatic test_sweep;
      logic [31:0] exp;
      for (int i = 0; i < 32; i++) begin
         do_write(5'(i), 32'(i * 4));
      end
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         #1;
         exp = (i < 31) ? 32'(i * 4) : 32'h0;
         checks++;
         if (ReadData1 !== exp) begin
            failures++;
            $display("FAIL sweep_rd1[%0d]: got %h want %h", i, ReadData1, exp);
         end
      end
   endtask

   task automatic test_reset_midrun;
      @(negedge clk);
      ReadRegister1 = 5'd3;
      ReadRegister2 = 5'd7;
      RegWrite      = 1'b1;
      WriteRegister = 5'd3;
      WriteData     = 32'h5555_AAAA;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (regs !== '0) begin
         failures++;
         $display("FAIL midrun_async_clear: got %h want all zero", regs);
      end
      checks++;
      if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
         failures++;
         $display("FAIL midrun_reads: rd1=%h rd2=%h want 0", ReadData1, ReadData2);
      end
      // Reset must win over a write presented on the same edge.
      @(posedge clk);
      #1;
      checks++;
      if (regs[3] !== 32'h0) begin
         failures++;
         $display("FAIL midrun_reset_wins: got %h want 00000000", regs[3]);
      end
      @(negedge clk);
      reset     = 1'b0;
      WriteData = 32'h0000_CAFE;
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      checks++;
      if (regs[3] !== 32'h0000_CAFE) begin
         failures++;
         $display("FAIL first_write_after_reset: got %h want 0000cafe", regs[3]);
      end
      checks++;
      if (regs[7] !== 32'h0) begin
         failures++;
         $display("FAIL post_reset_regs7: got %h want 00000000", regs[7]);
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_hold;
      test_zero_reg;
      test_bypass;
      test_back_to_back;
      test_sweep;
      test_reset_midrun;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
